// File: rtl/step_dir_generator_pkg.sv
// step_dir_generator_pkg: shared state encoding and step timing clamps
`timescale 1ns/1ps
package step_dir_generator_pkg;
  typedef enum logic [1:0] {IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW} state_t;
  function automatic logic [7:0] eff_width(input logic [7:0] w);
    return (w == 8'd0) ? 8'd1 : w;
  endfunction
  // period never shorter than width + 1, so step always spends a clock low
  function automatic logic [31:0] eff_period(input logic [31:0] p, input logic [7:0] w);
    logic [31:0] lo;
    lo = {24'd0, eff_width(w)} + 32'd1;
    return (p > lo) ? p : lo;
  endfunction
endpackage

// File: rtl/stepgen_timer.sv
// stepgen_timer: loadable down-counter that parks at zero and flags it
`timescale 1ns/1ps
module stepgen_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] count;
  assign zero = (count == '0);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (!zero) count <= count - W'(1);
endmodule

// File: rtl/step_dir_generator.sv
// step_dir_generator: command-driven step/dir pulse train generator with
// graceful abort and absolute position tracking
`timescale 1ns/1ps
module step_dir_generator
  import step_dir_generator_pkg::*;
#(
  parameter int COUNT_W  = 32,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                abort,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                cmd_dir,
  input  logic [7:0]          config_pulse_width,
  input  logic [7:0]          config_dir_setup,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                move_done,
  output logic                aborted,
  output logic [COUNT_W-1:0]  steps_remaining,
  output logic [COUNT_W-1:0]  position
);
  state_t state;
  logic stop, accept, stop_now, rise, pulse_zero, period_zero;
  logic [7:0] w_m1;
  logic [PERIOD_W-1:0] p_m1;
  assign cmd_ready = (state == IDLE) & enable & !reset;
  assign busy = (state != IDLE);
  assign accept = cmd_valid & cmd_ready;
  assign stop_now = stop | abort | !enable;
  assign rise = ((state == DIR_SETUP & pulse_zero) | (state == PULSE_LOW & period_zero)) & !stop_now;
  // one timer serves dir setup then pulse width; the other spans the full period
  stepgen_timer #(.W(8)) u_pulse (
    .clk(clk), .reset(reset), .load(accept | rise),
    .value(rise ? w_m1 : config_dir_setup), .zero(pulse_zero)
  );
  stepgen_timer #(.W(PERIOD_W)) u_period (
    .clk(clk), .reset(reset), .load(rise), .value(p_m1), .zero(period_zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      stop <= 1'b0;
      step <= 1'b0;
      dir <= 1'b0;
      move_done <= 1'b0;
      aborted <= 1'b0;
      steps_remaining <= '0;
      position <= '0;
      w_m1 <= '0;
      p_m1 <= '0;
    end else begin
      move_done <= 1'b0;
      aborted <= 1'b0;
      stop <= busy & stop_now;
      case (state)
        IDLE: if (accept) begin
          dir <= cmd_dir;
          steps_remaining <= cmd_steps;
          w_m1 <= eff_width(config_pulse_width) - 8'd1;
          p_m1 <= PERIOD_W'(eff_period(32'(cmd_period), config_pulse_width) - 32'd1);
          if (cmd_steps == '0) move_done <= 1'b1;
          else state <= DIR_SETUP;
        end
        PULSE_HIGH: if (pulse_zero) begin
          step <= 1'b0;
          if (stop_now | steps_remaining == '0) begin
            state <= IDLE;
            move_done <= 1'b1;
            aborted <= (steps_remaining != '0);
          end else state <= PULSE_LOW;
        end
        default: if (stop_now) begin
          state <= IDLE;
          move_done <= 1'b1;
          aborted <= 1'b1;
        end else if (rise) begin
          step <= 1'b1;
          state <= PULSE_HIGH;
          position <= dir ? position + COUNT_W'(1) : position - COUNT_W'(1);
          steps_remaining <= steps_remaining - COUNT_W'(1);
        end
      endcase
    end
endmodule

// File: tb/tb_step_dir_generator.sv
// tb_step_dir_generator: directed moves with a scoreboard of expected step
// rise times, pulse widths and move completions
`timescale 1ns/1ps
module tb_step_dir_generator;
  typedef struct {
    int          cyc;
    logic        ab;
    logic [31:0] pos;
    logic [31:0] rem;
    logic        d;
  } done_t;

  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, abort = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0;
  logic cmd_ready, step, dir, busy, move_done, aborted;
  logic [31:0] cmd_steps = '0, steps_remaining, position;
  logic [15:0] cmd_period = '0;
  logic [7:0] config_pulse_width = '0, config_dir_setup = '0;

  int cyc = 0, checks = 0, errors = 0, last_rise = 0;
  logic prev_step = 1'b0, prev_dir = 1'b0;
  int rise_q[$], w_q[$];
  done_t done_q[$];

  step_dir_generator dut (
    .clk(clk), .reset(reset), .enable(enable), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
    .cmd_period(cmd_period), .cmd_dir(cmd_dir),
    .config_pulse_width(config_pulse_width), .config_dir_setup(config_dir_setup),
    .step(step), .dir(dir), .busy(busy), .move_done(move_done), .aborted(aborted),
    .steps_remaining(steps_remaining), .position(position)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // observed at negedge: cyc equals the index of the edge that produced the value
  always @(negedge clk) begin
    if (!reset) begin
      if (step && !prev_step) begin
        if (rise_q.size() == 0) chk("rise_unexpected", 32'(rise_q.size()), 1);
        else chk("rise_cyc", cyc, rise_q.pop_front());
        last_rise <= cyc;
      end
      if (!step && prev_step) begin
        if (w_q.size() == 0) chk("fall_unexpected", 32'(w_q.size()), 1);
        else chk("width", cyc - last_rise, w_q.pop_front());
      end
      if (dir !== prev_dir) chk("dir_change_step_low", step, 0);
      if (move_done) begin
        if (done_q.size() == 0) chk("done_unexpected", 32'(done_q.size()), 1);
        else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_cyc", cyc, e.cyc);
          chk("done_aborted", aborted, e.ab);
          chk("done_position", position, e.pos);
          chk("done_remaining", steps_remaining, e.rem);
          chk("done_dir", dir, e.d);
        end
      end
    end else if (prev_step && !step && w_q.size() != 0) void'(w_q.pop_front());
    prev_step <= step;
    prev_dir <= dir;
  end

  task automatic send(input logic [31:0] n, input logic [15:0] p, input logic [7:0] w, input logic [7:0] s,
                      input logic d, input int nr, input logic push_done, input logic ab,
                      input logic [31:0] pos_end, output int k);
    int we, pe, t;
    t = 0;
    cmd_steps = n; cmd_period = p; config_pulse_width = w; config_dir_setup = s; cmd_dir = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    k = cyc;
    we = (w == 0) ? 1 : int'(w);
    pe = (int'(p) > we) ? int'(p) : we + 1;
    for (int i = 0; i < nr; i++) begin
      rise_q.push_back(k + int'(s) + 1 + i * pe);
      w_q.push_back(we);
    end
    if (push_done)
      done_q.push_back('{(n == 0) ? k : k + int'(s) + 1 + (nr - 1) * pe + we, ab, pos_end, n - 32'(nr), d});
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || done_q.size() != 0) && t < 2000) begin @(negedge clk); t++; end
    chk("idle_busy", busy, 0);
    chk("idle_done_q", 32'(done_q.size()), 0);
    @(negedge clk);
  endtask

  initial begin
    int k, kb;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", move_done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_remaining", steps_remaining, 0);
    chk("rst_position", position, 0);
    reset = 1'b0;
    @(negedge clk);
    // basic 3-step move: first rise setup+1 after accept, period 10, width 2
    send(3, 10, 2, 4, 1'b1, 3, 1'b1, 1'b0, 3, k);
    wait_idle();
    // zero-step command: immediate completion, dir still updated
    send(0, 10, 2, 4, 1'b0, 0, 1'b1, 1'b0, 3, k);
    wait_idle();
    // period shorter than width clamps to width + 1
    send(2, 2, 5, 0, 1'b1, 2, 1'b1, 1'b0, 5, k);
    wait_idle();
    // abort during the 7th high pulse: pulse completes, 93 steps left
    send(100, 8, 3, 2, 1'b1, 7, 1'b1, 1'b1, 12, k);
    wait_cyc(k + 3 + 6 * 8);
    chk("abort_step_high", step, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle();
    // back-to-back commands with a direction reversal
    send(4, 5, 1, 1, 1'b1, 4, 1'b1, 1'b0, 16, k);
    send(6, 4, 2, 3, 1'b0, 6, 1'b1, 1'b0, 10, kb);
    chk("b2b_accept_gap", kb - k, 19);
    wait_idle();
    chk("b2b_position", position, 10);
    // enable dropped during dir setup aborts with nothing issued
    send(5, 10, 2, 20, 1'b1, 0, 1'b0, 1'b0, 10, k);
    done_q.push_back('{cyc + 1, 1'b1, 32'd10, 32'd5, 1'b1});
    enable = 1'b0;
    @(negedge clk);
    chk("disabled_cmd_ready", cmd_ready, 0);
    wait_idle();
    enable = 1'b1;
    @(negedge clk);
    // reset in the middle of a high pulse
    send(4, 10, 5, 0, 1'b1, 1, 1'b0, 1'b0, 0, k);
    wait_cyc(k + 2);
    chk("pre_reset_step", step, 1);
    #1 reset = 1'b1;
    #1;
    chk("reset_step", step, 0);
    chk("reset_busy", busy, 0);
    chk("reset_position", position, 0);
    chk("reset_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    chk("end_rise_q", 32'(rise_q.size()), 0);
    chk("end_w_q", 32'(w_q.size()), 0);
    chk("end_done_q", 32'(done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
